// File: rtl/uart_tx_pkg.sv
// Shared types and output-mux select encodings for the UART transmit path.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_STOP  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, data, optional parity and stop phases,
// each one Baud_Tick long, with back-to-back acceptance on the stop tick.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Baud_Tick,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  output logic       Ready,
  output logic       Data_Load,
  output logic       Ser_En,
  output logic [1:0] Mux_Sel,
  output logic       Busy,
  output logic       Frame_Done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  tx_state_t        state_r, next_state_s;
  logic [CNT_W-1:0] bit_cnt_r, bit_cnt_nxt_s;
  logic             par_en_r, par_en_nxt_s;
  logic             load_s;

  // State, bit counter and latched parity enable
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= IDLE;
      bit_cnt_r <= '0;
      par_en_r  <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      par_en_r  <= par_en_nxt_s;
    end
  end

  // Acceptance qualifier; held off while reset is asserted
  always_comb begin
    load_s = 1'b0;
    if (RST && Baud_Tick && Data_Valid && (state_r == IDLE || state_r == STOP)) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  // Next-state, counter and parity-latch logic
  always_comb begin
    next_state_s  = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    par_en_nxt_s  = par_en_r;
    case (state_r)
      IDLE: begin
        if (load_s) begin
          next_state_s = START;
          par_en_nxt_s = PAR_EN;
        end else begin
          next_state_s = IDLE;
        end
      end
      START: begin
        if (Baud_Tick) begin
          next_state_s  = DATA;
          bit_cnt_nxt_s = '0;
        end else begin
          next_state_s = START;
        end
      end
      DATA: begin
        // Counter holds on the last bit so it never wraps inside a frame
        if (Baud_Tick && bit_cnt_r == CNT_LAST) begin
          next_state_s = par_en_r ? PARITY : STOP;
        end else if (Baud_Tick) begin
          bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
        end else begin
          next_state_s = DATA;
        end
      end
      PARITY: begin
        if (Baud_Tick) begin
          next_state_s = STOP;
        end else begin
          next_state_s = PARITY;
        end
      end
      STOP: begin
        if (load_s) begin
          next_state_s = START;
          par_en_nxt_s = PAR_EN;
        end else if (Baud_Tick) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = STOP;
        end
      end
      default: begin
        next_state_s  = IDLE;
        bit_cnt_nxt_s = '0;
        par_en_nxt_s  = 1'b0;
      end
    endcase
  end

  // Output decode: Moore on Mux_Sel/Busy, tick-qualified strobes
  always_comb begin
    Mux_Sel    = SEL_STOP;
    Busy       = 1'b0;
    Ready      = 1'b0;
    Data_Load  = load_s;
    Ser_En     = 1'b0;
    Frame_Done = 1'b0;
    case (state_r)
      IDLE: begin
        Mux_Sel = SEL_STOP;
        Ready   = RST & Baud_Tick;
      end
      START: begin
        Mux_Sel = SEL_START;
        Busy    = 1'b1;
      end
      DATA: begin
        Mux_Sel = SEL_DATA;
        Busy    = 1'b1;
        Ser_En  = RST & Baud_Tick;
      end
      PARITY: begin
        Mux_Sel = SEL_PAR;
        Busy    = 1'b1;
      end
      STOP: begin
        Mux_Sel    = SEL_STOP;
        Busy       = 1'b1;
        Ready      = RST & Baud_Tick;
        Frame_Done = RST & Baud_Tick;
      end
      default: begin
        Mux_Sel = SEL_STOP;
        Busy    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: per-cycle expected outputs are queued as
// stimulus is driven and compared on the following falling edge.
module tb_uart_tx_ctrl;
  import uart_tx_pkg::*;

  localparam int DW = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Baud_Tick = 1'b1;
  logic       Data_Valid = 1'b1;
  logic       PAR_EN = 1'b1;
  logic       Ready, Data_Load, Ser_En, Busy, Frame_Done;
  logic [1:0] Mux_Sel;

  int total = 0;
  int bad = 0;
  logic rst_v = 1'b0;

  logic [6:0] exp_q[$];
  string      tag_q[$];

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .Baud_Tick(Baud_Tick), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .Ready(Ready), .Data_Load(Data_Load), .Ser_En(Ser_En),
    .Mux_Sel(Mux_Sel), .Busy(Busy), .Frame_Done(Frame_Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (rdy,ld,ser,sel,busy,fd) at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] pk(input logic rdy, input logic ld, input logic ser,
                                    input logic [1:0] sel, input logic busy, input logic fd);
    return {rdy, ld, ser, sel, busy, fd};
  endfunction

  // Scoreboard pop and compare
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      chk(tag_q.pop_front(), {25'd0, Ready, Data_Load, Ser_En, Mux_Sel, Busy, Frame_Done},
          {25'd0, exp_q.pop_front()});
    end
  end

  task automatic cyc(input logic tick, input logic dv, input logic pe,
                     input logic [6:0] e, input string tag);
    @(posedge CLK);
    #1;
    RST = rst_v;
    Baud_Tick = tick;
    Data_Valid = dv;
    PAR_EN = pe;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // One bit phase of T clocks; tick-qualified outputs only on the last clock
  task automatic phase(input int t, input logic dv, input logic pe, input logic [1:0] sel,
                       input logic busy, input logic ser_t, input logic rdy_t,
                       input logic ld_t, input logic fd_t, input string tag);
    for (int i = 0; i < t - 1; i++) cyc(1'b0, dv, pe, pk(1'b0, 1'b0, 1'b0, sel, busy, 1'b0), tag);
    cyc(1'b1, dv, pe, pk(rdy_t, ld_t, ser_t, sel, busy, fd_t), tag);
  endtask

  task automatic send_frame(input int t, input logic p, input logic from_idle,
                            input logic nxt, input logic np);
    if (from_idle) phase(t, 1'b1, p, SEL_STOP, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "accept");
    phase(t, 1'b0, ~p, SEL_START, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "start");
    for (int b = 0; b < DW; b++) begin
      phase(t, 1'b0, p ^ b[0] ^ 1'b1, SEL_DATA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "data");
    end
    if (p) phase(t, 1'b0, ~p, SEL_PAR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "parity");
    phase(t, nxt, np, SEL_STOP, 1'b1, 1'b0, 1'b1, nxt, 1'b1, "stop");
  endtask

  task automatic idle_chk();
    cyc(1'b1, 1'b0, 1'b0, pk(1'b1, 1'b0, 1'b0, SEL_STOP, 1'b0, 1'b0), "idle");
  endtask

  initial begin
    // Reset held with valid and tick high: nothing accepted
    rst_v = 1'b0;
    repeat (3) cyc(1'b1, 1'b1, 1'b1, pk(1'b0, 1'b0, 1'b0, SEL_STOP, 1'b0, 1'b0), "rst_hold");
    rst_v = 1'b1;
    send_frame(1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_chk();
    send_frame(1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_chk();
    send_frame(4, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_chk();
    // Valid without tick is ignored
    repeat (2) cyc(1'b0, 1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, SEL_STOP, 1'b0, 1'b0), "no_tick");
    // Back-to-back frames, no idle gap
    send_frame(1, 1'b0, 1'b1, 1'b1, 1'b1);
    send_frame(1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(3, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_chk();
    // Reset during data bit 3
    phase(1, 1'b1, 1'b1, SEL_STOP, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "accept");
    phase(1, 1'b0, 1'b0, SEL_START, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "start");
    repeat (3) phase(1, 1'b0, 1'b0, SEL_DATA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "data");
    rst_v = 1'b0;
    repeat (2) cyc(1'b1, 1'b0, 1'b1, pk(1'b0, 1'b0, 1'b0, SEL_STOP, 1'b0, 1'b0), "rst_mid");
    rst_v = 1'b1;
    idle_chk();
    send_frame(2, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_chk();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
